// File: rtl/pio_bank_pkg.sv
// Shared constants for the pio_bank_sync Avalon PIO bank: register map, bit positions, shadow ops.
package pio_bank_pkg;

    localparam int COMMIT_CNT_W = 16;

    // Page 0 register offsets (per channel)
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_SET    = 2'd1;
    localparam logic [1:0] REG_CLR    = 2'd2;
    localparam logic [1:0] REG_ACTIVE = 2'd3;

    // Page 1 register offsets (global)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COMMIT = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int CTRL_IMM     = 0;
    localparam int CTRL_SYNC_EN = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_W       = 3;

    localparam int STAT_PENDING = 0;
    localparam int STAT_IRQ     = 1;
    localparam int STAT_CNT_LSB = 16;

    typedef enum logic [1:0] {
        OP_DATA = 2'd0,
        OP_SET  = 2'd1,
        OP_CLR  = 2'd2
    } shadow_op_e;

    function automatic int chan_idx_w(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/pio_bank_channel.sv
// One output channel: CPU-visible shadow register plus the committed active register.
module pio_bank_channel
    import pio_bank_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  shadow_op_e        wr_op_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              commit_i,
    output logic [DATA_W-1:0] shadow_o,
    output logic [DATA_W-1:0] active_o
);

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            case (wr_op_i)
                OP_SET:  shadow_d = shadow_q | wr_data_i;
                OP_CLR:  shadow_d = shadow_q & ~wr_data_i;
                default: shadow_d = wr_data_i;
            endcase
        end
    end

    // Commit takes shadow_d so a write landing in the commit cycle goes live with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= RESET_VALUE;
            active_q <= RESET_VALUE;
        end else begin
            shadow_q <= shadow_d;
            if (commit_i) begin
                active_q <= shadow_d;
            end
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;

endmodule

// File: rtl/pio_bank_sync.sv
// Multi-channel Avalon-MM PIO with shadow/active registers, sync-aligned commit, counter and sticky IRQ.
module pio_bank_sync
    import pio_bank_pkg::*;
#(
    parameter int                CH          = 4,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    localparam int               CHW         = chan_idx_w(CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHW+2:0]       address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic                 read_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic                 sync_in,
    output logic [CH*DATA_W-1:0] out_port,
    output logic                 irq
);

    localparam logic [CHW:0] CH_COUNT = (CHW+1)'(CH);

    logic              wr_en, rd_en, page_sel, chan_valid;
    logic [CHW-1:0]    chan_sel;
    logic [1:0]        reg_sel;
    logic              ch_wr, ctrl_wr, commit_wr, status_wr;
    logic              commit, commit_event;
    shadow_op_e        ch_op;

    logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic                    pending_q, pending_d;
    logic [COMMIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                    irq_flag_q, irq_flag_d;
    logic [31:0]             readdata_q, readdata_d;

    logic [DATA_W-1:0] shadow_w [CH];
    logic [DATA_W-1:0] active_w [CH];

    assign wr_en      = chipselect & ~write_n;
    assign rd_en      = chipselect & ~read_n;
    assign page_sel   = address[CHW+2];
    assign chan_sel   = address[CHW+1:2];
    assign reg_sel    = address[1:0];
    assign chan_valid = ({1'b0, chan_sel} < CH_COUNT);

    assign ch_wr     = wr_en & ~page_sel & chan_valid & (reg_sel != REG_ACTIVE);
    assign ctrl_wr   = wr_en &  page_sel & (reg_sel == REG_CTRL);
    assign commit_wr = wr_en &  page_sel & (reg_sel == REG_COMMIT);
    assign status_wr = wr_en &  page_sel & (reg_sel == REG_STATUS);

    always_comb begin
        case (reg_sel)
            REG_SET: ch_op = OP_SET;
            REG_CLR: ch_op = OP_CLR;
            default: ch_op = OP_DATA;
        endcase
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        logic hit;
        assign hit = ch_wr & (chan_sel == CHW'(gi));

        pio_bank_channel #(
            .DATA_W      (DATA_W),
            .RESET_VALUE (RESET_VALUE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (hit),
            .wr_op_i   (ch_op),
            .wr_data_i (writedata[DATA_W-1:0]),
            .commit_i  (commit),
            .shadow_o  (shadow_w[gi]),
            .active_o  (active_w[gi])
        );

        assign out_port[gi*DATA_W +: DATA_W] = active_w[gi];
    end

    // A write in the commit cycle counts as pending, so it makes the commit an event.
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d = writedata[CTRL_W-1:0];
        end
        commit       = ctrl_q[CTRL_IMM] | commit_wr | (ctrl_q[CTRL_SYNC_EN] & sync_in);
        commit_event = commit & (pending_q | ch_wr | commit_wr);
        pending_d    = commit ? 1'b0 : (pending_q | ch_wr);
        cnt_d        = commit_event ? cnt_q + COMMIT_CNT_W'(1) : cnt_q;
        irq_flag_d   = irq_flag_q;
        if (status_wr && writedata[STAT_IRQ]) begin
            irq_flag_d = 1'b0;
        end
        if (commit_event && ctrl_q[CTRL_IRQ_EN]) begin
            irq_flag_d = 1'b1;
        end
    end

    always_comb begin
        readdata_d = '0;
        if (rd_en) begin
            if (!page_sel) begin
                if (chan_valid) begin
                    if (reg_sel == REG_ACTIVE) begin
                        readdata_d[DATA_W-1:0] = active_w[chan_sel];
                    end else begin
                        readdata_d[DATA_W-1:0] = shadow_w[chan_sel];
                    end
                end
            end else begin
                case (reg_sel)
                    REG_CTRL: readdata_d[CTRL_W-1:0] = ctrl_q;
                    REG_STATUS: begin
                        readdata_d[STAT_PENDING]                    = pending_q;
                        readdata_d[STAT_IRQ]                        = irq_flag_q;
                        readdata_d[STAT_CNT_LSB +: COMMIT_CNT_W]    = cnt_q;
                    end
                    default: readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            irq_flag_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            irq_flag_q <= irq_flag_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_flag_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_pio_bank_sync.sv
// Self-checking bench for pio_bank_sync: directed scenarios plus random traffic against a register-map model.
module tb_pio_bank_sync;

    localparam int          CH     = 5;
    localparam int          DATA_W = 32;
    localparam int          AW     = 6;
    localparam logic [31:0] RV     = 32'h0000_00F0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AW-1:0]        address;
    logic                 chipselect, write_n, read_n;
    logic [31:0]          writedata, readdata;
    logic                 sync_in;
    logic [CH*DATA_W-1:0] out_port;
    logic                 irq;

    always #5 clk = ~clk;

    pio_bank_sync #(.CH(CH), .DATA_W(DATA_W), .RESET_VALUE(RV)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sync_in    (sync_in),
        .out_port   (out_port),
        .irq        (irq)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_shadow [CH];
    logic [31:0] m_active [CH];
    logic [2:0]  m_ctrl;
    bit          m_pending;
    int          m_cnt;
    bit          m_irqf;
    logic [31:0] exp_rd;

    function automatic logic [AW-1:0] addr(input bit page, input int chan, input int rg);
        logic [2:0] c;
        logic [1:0] r;
        c = chan[2:0];
        r = rg[1:0];
        return {page, c, r};
    endfunction

    function automatic logic [CH*DATA_W-1:0] exp_out();
        logic [CH*DATA_W-1:0] v;
        for (int k = 0; k < CH; k++) v[k*DATA_W +: DATA_W] = m_active[k];
        return v;
    endfunction

    function automatic logic exp_irq();
        return m_irqf && m_ctrl[2];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [15:0] c;
        c = m_cnt[15:0];
        return {c, 14'b0, m_irqf, m_pending};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_shadow[k] = RV;
            m_active[k] = RV;
        end
        m_ctrl = 3'b0; m_pending = 0; m_cnt = 0; m_irqf = 0; exp_rd = 32'h0;
    endtask

    // One bus cycle of the register map, evaluated on the state before the clock edge.
    task automatic model_step(input bit w, input bit r, input logic [AW-1:0] a,
                              input logic [31:0] d, input bit s);
        bit page, dirty, cwr, commit, ev;
        int chan, rg;
        page = a[5];
        chan = int'(a[4:2]);
        rg   = int'(a[1:0]);
        exp_rd = 32'h0;
        if (r) begin
            if (!page) begin
                if (chan < CH) exp_rd = (rg == 3) ? m_active[chan] : m_shadow[chan];
            end else if (rg == 0) begin
                exp_rd = {29'b0, m_ctrl};
            end else if (rg == 2) begin
                exp_rd = exp_status();
            end
        end
        dirty = w && !page && (chan < CH) && (rg != 3);
        if (dirty) begin
            if (rg == 0)      m_shadow[chan] = d;
            else if (rg == 1) m_shadow[chan] = m_shadow[chan] | d;
            else              m_shadow[chan] = m_shadow[chan] & ~d;
        end
        cwr    = w && page && (rg == 1);
        commit = m_ctrl[0] || cwr || (m_ctrl[1] && s);
        ev     = 0;
        if (commit) begin
            ev = m_pending || dirty || cwr;
            for (int k = 0; k < CH; k++) m_active[k] = m_shadow[k];
            m_pending = 0;
        end else if (dirty) begin
            m_pending = 1;
        end
        if (w && page && (rg == 2) && d[1]) m_irqf = 0;
        if (ev) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_ctrl[2]) m_irqf = 1;
        end
        if (w && page && (rg == 0)) m_ctrl = d[2:0];
    endtask

    task automatic bus(input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [31:0] d, input bit s);
        chipselect = w | r;
        write_n    = !w;
        read_n     = !r;
        address    = a;
        writedata  = d;
        sync_in    = s;
        model_step(w, r, a, d, s);
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; sync_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; sync_in = 1'b0;
        address = '0; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL reset_out got=%h want=%h", out_port, exp_out());
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h want=0", readdata); end
        reset = 1'b0;
        for (int k = 0; k < CH; k++) begin
            bus(0, 1, addr(0, k, 3), 32'h0, 0);
            checks++;
            if (readdata !== RV) begin
                errors++; $display("FAIL reset_active ch%0d got=%h want=%h", k, readdata, RV);
            end
            $display("reset: ACTIVE ch%0d = %h", k, readdata);
        end
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_status got=%h want=0", readdata); end
    endtask

    task automatic test_commit_explicit();
        bus(1, 0, addr(1, 0, 0), 32'h0, 0);
        bus(1, 0, addr(0, 1, 0), 32'h0000_1234, 0);
        checks++;
        if (out_port[63:32] !== RV) begin
            errors++; $display("FAIL explicit_hold got=%h want=%h", out_port[63:32], RV);
        end
        bus(0, 0, addr(0, 0, 0), 32'h0, 1);
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL explicit_sync_ignored got=%h want=%h", out_port, exp_out());
        end
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== 32'h0000_0001) begin
            errors++; $display("FAIL explicit_pending got=%h want=00000001", readdata);
        end
        bus(1, 0, addr(1, 0, 1), 32'h0, 0);
        checks++;
        if (out_port[63:32] !== 32'h0000_1234) begin
            errors++; $display("FAIL explicit_commit got=%h want=00001234", out_port[63:32]);
        end
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== 32'h0001_0000) begin
            errors++; $display("FAIL explicit_status got=%h want=00010000", readdata);
        end
        $display("explicit commit: ch1=%h status=%h", out_port[63:32], readdata);
    endtask

    task automatic test_sync_irq();
        bus(1, 0, addr(1, 0, 0), 32'h6, 0);
        bus(1, 0, addr(0, 2, 0), 32'h0000_00A5, 0);
        bus(1, 0, addr(0, 2, 1), 32'h0000_0100, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL sync_irq_early got=%b want=0", irq); end
        bus(0, 0, addr(0, 0, 0), 32'h0, 1);
        checks++;
        if (out_port[95:64] !== 32'h0000_01A5) begin
            errors++; $display("FAIL sync_commit got=%h want=000001a5", out_port[95:64]);
        end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL sync_irq got=%b want=1", irq); end
        bus(1, 0, addr(1, 0, 2), 32'h0000_0002, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL sync_w1c got=%b want=0", irq); end
        $display("sync commit: ch2=%h irq=%b", out_port[95:64], irq);
    endtask

    task automatic test_write_with_sync();
        bus(1, 0, addr(0, 0, 0), 32'h0000_0055, 1);
        checks++;
        if (out_port[31:0] !== 32'h0000_0055) begin
            errors++; $display("FAIL wsync_out got=%h want=00000055", out_port[31:0]);
        end
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== exp_rd || readdata[0] !== 1'b0) begin
            errors++; $display("FAIL wsync_status got=%h want=%h", readdata, exp_rd);
        end
        $display("write+sync: ch0=%h status=%h", out_port[31:0], readdata);
    endtask

    task automatic test_imm_and_range();
        bus(1, 0, addr(1, 0, 0), 32'h1, 0);
        bus(1, 0, addr(0, 3, 2), 32'hFFFF_FFFF, 0);
        checks++;
        if (out_port[127:96] !== 32'h0) begin
            errors++; $display("FAIL imm_clr got=%h want=0", out_port[127:96]);
        end
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata[0] !== 1'b0) begin errors++; $display("FAIL imm_pending got=%b want=0", readdata[0]); end
        bus(1, 0, addr(0, 5, 0), 32'hCAFE_F00D, 0);
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL range_write got=%h want=%h", out_port, exp_out());
        end
        bus(0, 1, addr(0, 5, 0), 32'h0, 0);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL range_read got=%h want=0", readdata); end
        $display("imm/range: ch3=%h chan5 read=%h", out_port[127:96], readdata);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int kind;
            bit w, r, s;
            logic [AW-1:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 9);
            d = $urandom;
            s = $urandom_range(0, 1) == 1;
            w = 0; r = 0;
            a = addr(0, $urandom_range(0, 7), $urandom_range(0, 3));
            case (kind)
                0, 1, 2: w = 1;
                3:       r = 1;
                4: begin w = 1; a = addr(1, 0, 0); d = {29'b0, 3'($urandom_range(0, 7))}; end
                5: begin w = 1; a = addr(1, 0, 1); end
                6: begin r = 1; a = addr(1, $urandom_range(0, 7), $urandom_range(0, 3)); end
                7: begin w = 1; a = addr(1, 0, 2); end
                default: ;
            endcase
            bus(w, r, a, d, s);
            checks++;
            if (readdata !== exp_rd) begin
                errors++; $display("FAIL rand_rd i=%0d got=%h want=%h", i, readdata, exp_rd);
            end
            checks++;
            if (out_port !== exp_out()) begin
                errors++; $display("FAIL rand_out i=%0d got=%h want=%h", i, out_port, exp_out());
            end
            checks++;
            if (irq !== exp_irq()) begin
                errors++; $display("FAIL rand_irq i=%0d got=%b want=%b", i, irq, exp_irq());
            end
            $display("rand %0d: w=%b r=%b a=%h d=%h s=%b rd=%h irq=%b", i, w, r, a, d, s, readdata, irq);
        end
    endtask

    task automatic test_reset_mid();
        bus(1, 0, addr(1, 0, 0), 32'h4, 0);
        bus(1, 0, addr(0, 4, 0), 32'h0000_DEAD, 0);
        bus(1, 0, addr(1, 0, 1), 32'h0, 0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got=%b want=1", irq); end
        bus(1, 0, addr(0, 4, 0), 32'h0000_BEEF, 0);
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_port !== exp_out()) begin
            errors++; $display("FAIL mid_out got=%h want=%h", out_port, exp_out());
        end
        checks++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            errors++; $display("FAIL mid_irq_rd got irq=%b rd=%h want irq=0 rd=0", irq, readdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus(0, 1, addr(0, 4, 0), 32'h0, 0);
        checks++;
        if (readdata !== RV) begin errors++; $display("FAIL mid_shadow got=%h want=%h", readdata, RV); end
        $display("reset mid-run: out=%h shadow4=%h", out_port, readdata);
    endtask

    task automatic test_wrap();
        bus(1, 0, addr(1, 0, 0), 32'h0, 0);
        for (int i = 0; i < 65535; i++) bus(1, 0, addr(1, 0, 1), 32'h0, 0);
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== 32'hFFFF_0000) begin
            errors++; $display("FAIL wrap_ffff got=%h want=ffff0000", readdata);
        end
        bus(1, 0, addr(1, 0, 1), 32'h0, 0);
        bus(0, 1, addr(1, 0, 2), 32'h0, 0);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h want=0", readdata); end
        $display("counter wrap: status=%h", readdata);
    endtask

    initial begin
        test_reset();
        test_commit_explicit();
        test_sync_irq();
        test_write_with_sync();
        test_imm_and_range();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
